// File: rtl/loader_wr_queue_pkg.sv
// Shared types and constants for the ROM-download write path.
package nes_loader_pkg;

    localparam int LOADER_AW = 22;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wrq_state_t;

endpackage

// File: rtl/loader_wr_queue_if.sv
// Loader-side strobe inputs and SDRAM-side write outputs of the write queue.
interface loader_wr_queue_if
    import nes_loader_pkg::*;
#(
    parameter int AW = LOADER_AW
);
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic [7:0]    in_data;
    logic          out_we;
    logic [AW-1:0] out_addr;
    logic [7:0]    out_data;

    modport master (
        output in_valid, in_addr, in_data,
        input  out_we, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_addr, in_data,
        output out_we, out_addr, out_data
    );
endinterface

// File: rtl/loader_wrq_fifo.sv
// Plain synchronous FIFO with push/pop strobes; pointers carry one extra wrap bit.
module loader_wrq_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 30,
    localparam int IW   = $clog2(DEPTH),
    localparam int PW   = IW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [PW-1:0] count
);
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        mem_d = mem_q;
        if (push) begin
            mem_d[wp_q[IW-1:0]] = wdata;
            wp_d                = wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = rp_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rp_q[IW-1:0]];
    assign count = wp_q - rp_q;

endmodule

// File: rtl/loader_wr_queue.sv
// Queues loader byte writes and replays each for one NES CE period from the CPU slot.
// Optional LOADER_WRQ_STATS_EN adds wr_count / wr_sum download-verification outputs.
module loader_wr_queue
    import nes_loader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = LOADER_AW
) (
    input  logic               clk,
    input  logic               reset,
    loader_wr_queue_if.slave   bus,
    input  logic               slot,
    output logic               empty,
    output logic               full,
    output logic               overflow
`ifdef LOADER_WRQ_STATS_EN
    ,
    output logic [23:0]        wr_count,
    output logic [15:0]        wr_sum
`endif
);
    localparam int            PW      = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

    logic [PW-1:0] count;
    logic [AW+7:0] head;
    logic          push;
    logic          pop;

    wrq_state_t    state_q, state_d;
    logic          out_we_q, out_we_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          overflow_q, overflow_d;

    // Pop uses the registered count, so a strobe arriving in the slot cycle waits.
    assign pop  = slot && (count != '0);
    assign push = bus.in_valid && ((count < DEPTH_C) || pop);

    loader_wrq_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + 8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({bus.in_addr, bus.in_data}),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    always_comb begin
        state_d    = state_q;
        out_we_d   = out_we_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q | (bus.in_valid & ~push);
        case (state_q)
            IDLE: begin
                out_we_d = 1'b0;
                if (pop) begin
                    state_d    = ISSUE;
                    out_we_d   = 1'b1;
                    out_addr_d = head[AW+7:8];
                    out_data_d = head[7:0];
                end
            end
            ISSUE: begin
                if (slot) begin
                    if (pop) begin
                        out_we_d   = 1'b1;
                        out_addr_d = head[AW+7:8];
                        out_data_d = head[7:0];
                    end else begin
                        state_d  = IDLE;
                        out_we_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                out_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_we   = out_we_q;
    assign bus.out_addr = out_addr_q;
    assign bus.out_data = out_data_q;
    assign empty        = (count == '0) && (state_q == IDLE);
    assign full         = (count == DEPTH_C);
    assign overflow     = overflow_q;

`ifdef LOADER_WRQ_STATS_EN
    logic [23:0] wr_count_q, wr_count_d;
    logic [15:0] wr_sum_q, wr_sum_d;

    always_comb begin
        wr_count_d = wr_count_q;
        wr_sum_d   = wr_sum_q;
        if (pop) begin
            wr_count_d = wr_count_q + 24'd1;
            wr_sum_d   = wr_sum_q + {8'h00, head[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
            wr_sum_q   <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            wr_sum_q   <= wr_sum_d;
        end
    end

    assign wr_count = wr_count_q;
    assign wr_sum   = wr_sum_q;
`endif

endmodule

// File: tb/tb_loader_wr_queue.sv
// Directed bench for loader_wr_queue; stats checks compile in with LOADER_WRQ_STATS_EN.
module tb_loader_wr_queue;
    import nes_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic slot;
    logic empty, full, overflow;
`ifdef LOADER_WRQ_STATS_EN
    logic [23:0] wr_count;
    logic [15:0] wr_sum;
`endif

    loader_wr_queue_if #(.AW(LOADER_AW)) bus ();

    loader_wr_queue #(
        .DEPTH (8),
        .AW    (LOADER_AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .slot     (slot),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
`ifdef LOADER_WRQ_STATS_EN
        ,
        .wr_count (wr_count),
        .wr_sum   (wr_sum)
`endif
    );

    int checks = 0;
    int errors = 0;

    bit slot_en = 1'b0;
    int phase   = 0;

    // Write monitor: each issued write as {addr, data} and its hold length in clocks.
    logic [29:0] wr_q [$];
    int          len_q [$];
    int          cur_len   = 0;
    int          falls     = 0;
    bit          prev_we   = 1'b0;
    bit          last_slot = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [21:0] a, input logic [7:0] d, input bit r);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        reset        = r;
        slot         = slot_en && (phase == 3);
        last_slot    = slot;
        phase        = (phase + 1) % 4;
        @(posedge clk);
        #1;
        if (bus.out_we && last_slot) begin
            if (cur_len > 0) len_q.push_back(cur_len);
            wr_q.push_back({bus.out_addr, bus.out_data});
            cur_len = 1;
        end else if (bus.out_we) begin
            cur_len++;
        end else if (cur_len > 0) begin
            len_q.push_back(cur_len);
            cur_len = 0;
        end
        if (prev_we && !bus.out_we) falls++;
        prev_we = bus.out_we;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 22'h0, 8'h00, 1'b0);
    endtask

    task automatic clear_mon();
        wr_q.delete();
        len_q.delete();
        falls   = 0;
        cur_len = 0;
    endtask

    task automatic do_reset();
        slot_en = 1'b0;
        cyc(1'b0, 22'h0, 8'h00, 1'b1);
        cyc(1'b0, 22'h0, 8'h00, 1'b1);
        clear_mon();
    endtask

    initial begin
        reset        = 1'b1;
        slot         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;

        // Reset values
        do_reset();
        chk("rst_we",       32'(bus.out_we),   32'd0);
        chk("rst_addr",     32'(bus.out_addr), 32'd0);
        chk("rst_data",     32'(bus.out_data), 32'd0);
        chk("rst_empty",    32'(empty),        32'd1);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_overflow", 32'(overflow),     32'd0);

        // Single write, slot every 4 clocks
        slot_en = 1'b1;
        phase   = 0;
        cyc(1'b1, 22'h000010, 8'hA5, 1'b0);
        chk("t1_counted_next_cycle", 32'(empty), 32'd0);
        chk("t1_no_bypass_we", 32'(bus.out_we), 32'd0);
        idle(20);
        chk("t1_nwrites", 32'(wr_q.size()), 32'd1);
        chk("t1_write", 32'(wr_q[0]), 32'({22'h000010, 8'hA5}));
        chk("t1_nlen", 32'(len_q.size()), 32'd1);
        chk("t1_len", 32'(len_q[0]), 32'd4);
        chk("t1_empty_after", 32'(empty), 32'd1);

        // Burst of 5 on consecutive clocks
        clear_mon();
        for (int i = 1; i <= 5; i++) cyc(1'b1, 22'(32'h100 + i), 8'(i), 1'b0);
        idle(40);
        chk("t2_nwrites", 32'(wr_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_write%0d", i), 32'(wr_q[i]), 32'({22'(32'h101 + i), 8'(i + 1)}));
            chk($sformatf("t2_len%0d", i), 32'(len_q[i]), 32'd4);
        end
        chk("t2_we_single_fall", 32'(falls), 32'd1);
        chk("t2_overflow", 32'(overflow), 32'd0);

        // DEPTH+2 strobes with no slot
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 22'(32'h200 + i), 8'(i), 1'b0);
            if (i == 7) chk("t3_not_full_at7", 32'(full), 32'd0);
            if (i == 8) begin
                chk("t3_full_at8", 32'(full), 32'd1);
                chk("t3_no_ovf_at8", 32'(overflow), 32'd0);
            end
        end
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_full", 32'(full), 32'd1);
        slot_en = 1'b1;
        phase   = 0;
        idle(60);
        chk("t3_nwrites", 32'(wr_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t3_write%0d", i), 32'(wr_q[i]), 32'({22'(32'h201 + i), 8'(i + 1)}));
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Push coinciding with a slot pop while full
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 22'(32'h300 + i), 8'(i), 1'b0);
        chk("t4_full_before", 32'(full), 32'd1);
        slot_en = 1'b1;
        phase   = 3;
        cyc(1'b1, 22'h3FFFFF, 8'h99, 1'b0);
        slot_en = 1'b0;
        chk("t4_count_stays_full", 32'(full), 32'd1);
        chk("t4_no_overflow", 32'(overflow), 32'd0);
        chk("t4_we", 32'(bus.out_we), 32'd1);
        slot_en = 1'b1;
        phase   = 0;
        idle(60);
        chk("t4_nwrites", 32'(wr_q.size()), 32'd9);
        chk("t4_first", 32'(wr_q[0]), 32'({22'h000301, 8'h01}));
        chk("t4_eighth", 32'(wr_q[7]), 32'({22'h000308, 8'h08}));
        chk("t4_pushed_last", 32'(wr_q[8]), 32'({22'h3FFFFF, 8'h99}));

        // Reset while a write is in flight with 3 entries queued
        do_reset();
        slot_en = 1'b1;
        phase   = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 22'(32'h400 + i), 8'(32'h11 + i), 1'b0);
        chk("t5_we_before", 32'(bus.out_we), 32'd1);
        chk("t5_not_empty", 32'(empty), 32'd0);
        cyc(1'b0, 22'h0, 8'h00, 1'b1);
        chk("t5_we_after_rst", 32'(bus.out_we), 32'd0);
        chk("t5_empty_after_rst", 32'(empty), 32'd1);
        clear_mon();
        idle(20);
        chk("t5_no_writes", 32'(wr_q.size()), 32'd0);
        chk("t5_we_idle", 32'(bus.out_we), 32'd0);

`ifdef LOADER_WRQ_STATS_EN
        // Statistics over four 0xFF writes
        do_reset();
        chk("t6_count_rst", 32'(wr_count), 32'd0);
        chk("t6_sum_rst", 32'(wr_sum), 32'd0);
        slot_en = 1'b1;
        phase   = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 22'(32'h500 + i), 8'hFF, 1'b0);
        idle(30);
        chk("t6_wr_count", 32'(wr_count), 32'd4);
        chk("t6_wr_sum", 32'(wr_sum), 32'h03FC);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
